symbol_depacketizer: RTL and testbench

Next-generation receive depacketizer. It takes the demodulated symbol stream after boundary detection, skips the residual training window and parses a protected 32-bit header (length, MCS, check). It then packs BPSK (1 bit/symbol) or QPSK (2 bits/symbol) payload symbols into BYTES-wide AXI-Stream words through a small output FIFO. It sits between the symbol decision stage and the DMA/AXIS sink. Unlike the previous generation, it supports per-packet modulation from the header, word packing, tkeep, backpressure buffering and error reporting.

---
 rtl/symbol_depacketizer_pkg.sv | 33 +++
 rtl/symbol_depacketizer_axis_word_fifo.sv | 47 ++++
 rtl/symbol_depacketizer.sv | 194 +++++++++++++++++++
 tb/tb_symbol_depacketizer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/symbol_depacketizer_pkg.sv
// Shared encodings for the symbol depacketizer: mode select, FSM states,
// header field layout and helpers for header check and modulation choice.
package symbol_depacketizer_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_HDR   = 2'd2;
    localparam logic [1:0] ST_PLD   = 2'd3;

    localparam int HDR_SYMS    = 32;
    localparam int HDR_LEN_LSB = 16;
    localparam int HDR_MCS_LSB = 8;
    localparam int HDR_CHK_LSB = 0;

    localparam logic [7:0] MCS_BPSK     = 8'h00;
    localparam logic [7:0] MCS_QPSK     = 8'h01;
    localparam int         MCS_QPSK_BIT = 0;

    function automatic logic hdr_chk_ok(input logic [31:0] hdr);
        return hdr[HDR_CHK_LSB +: 8] ==
               (hdr[HDR_LEN_LSB+8 +: 8] ^ hdr[HDR_LEN_LSB +: 8] ^ hdr[HDR_MCS_LSB +: 8]);
    endfunction

    // Unknown mode codes fall back to header-selected modulation.
    function automatic logic pick_bpsk(input logic [3:0] mode, input logic [7:0] mcs);
        return (mode == MODE_BPSK) || ((mode != MODE_QPSK) && !mcs[MCS_QPSK_BIT]);
    endfunction

endpackage

// File: rtl/symbol_depacketizer_axis_word_fifo.sv
// First-word-fall-through word FIFO; accepts a push while full when a pop
// frees a slot in the same cycle. Output reads as zero while empty.
module axis_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/symbol_depacketizer.sv
// Receive depacketizer: skips the training guard, parses the protected header
// and packs BPSK/QPSK payload symbols into AXI-Stream words via a small FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a qualified BD_flag
// ST_GUARD | discarding the remaining training symbols
// ST_HDR   | shifting in 32 BPSK header symbols (len, mcs, chk)
// ST_PLD   | packing payload bits into words until 8*len bits are seen
module symbol_depacketizer
    import symbol_depacketizer_pkg::*;
#(
    parameter int BYTES            = 1,
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int GUARD_SYMS       = 30,
    parameter int LEN_WIDTH        = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic [3:0]                  MODE_CTRL,
    input  logic                        BD_flag,
    input  logic                        BD_sgn,
    input  logic                        sym_valid,
    input  logic [1:0]                  in_QPSK,
    output logic [8*BYTES-1:0]          data_tdata,
    output logic [BYTES-1:0]            data_tkeep,
    output logic                        data_tvalid,
    input  logic                        data_tready,
    output logic                        data_tlast,
    output logic                        data_tuser,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        hdr_err,
    output logic                        ovf_err
);
    localparam int BITS = 8 * BYTES;
    localparam int CW   = $clog2(BITS) + 1;
    localparam int RW   = LEN_WIDTH + 3;
    localparam int GW   = MAX_WINDOW_WIDTH + 2;
    localparam int FW   = BITS + BYTES + 2;

    logic [1:0]       state;
    logic             sgn;
    logic             is_bpsk;
    logic [GW-1:0]    guard_cnt;
    logic [4:0]       hdr_cnt;
    logic [30:0]      hdr_sr;
    logic [RW-1:0]    rem_bits;
    logic [BITS-2:0]  pack;
    logic [CW-1:0]    wcnt;

    logic signed [GW-1:0] guard_len;
    logic             b_i;
    logic             b_q;
    logic [31:0]      hdr_next;
    logic [BITS-1:0]  pack_next;
    logic [CW-1:0]    wcnt_next;
    logic [RW-1:0]    rem_next;
    logic [BITS-1:0]  push_data;
    logic [BYTES-1:0] push_keep;
    logic             pld_last;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    push_word;
    logic [FW-1:0]    pop_word;

    assign guard_len = $signed(GW'(GUARD_SYMS)) - $signed({2'b00, RX_BD_WINDOW});
    assign b_i       = in_QPSK[1] ^ sgn;
    assign b_q       = in_QPSK[0] ^ sgn;
    assign hdr_next  = {hdr_sr, b_i};

    always_comb begin
        pack_next = '0;
        wcnt_next = wcnt;
        rem_next  = rem_bits;
        if (is_bpsk || rem_bits == RW'(1)) begin
            pack_next = {pack, b_i};
            wcnt_next = wcnt + CW'(1);
            rem_next  = rem_bits - RW'(1);
        end else begin
            pack_next = {pack[BITS-3:0], b_i, b_q};
            wcnt_next = wcnt + CW'(2);
            rem_next  = rem_bits - RW'(2);
        end
    end

    assign pld_last = (rem_next == '0);
    assign push     = (state == ST_PLD) && sym_valid && ((wcnt_next == CW'(BITS)) || pld_last);

    // A short final word is left-justified so the first payload bit stays at the MSB.
    always_comb begin
        push_data = pack_next << (CW'(BITS) - wcnt_next);
        push_keep = '0;
        for (int i = 0; i < BYTES; i++) begin
            push_keep[BYTES-1-i] = (wcnt_next > CW'(8*i));
        end
    end

    assign push_word = {push_data, push_keep, pld_last, is_bpsk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sgn       <= 1'b0;
            is_bpsk   <= 1'b0;
            guard_cnt <= '0;
            hdr_cnt   <= '0;
            hdr_sr    <= '0;
            rem_bits  <= '0;
            pack      <= '0;
            wcnt      <= '0;
            pkt_done  <= 1'b0;
            hdr_err   <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            hdr_err  <= 1'b0;
            if (push && fifo_full && !data_tready) ovf_err <= 1'b1;
            if (sym_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (BD_flag) begin
                            sgn       <= BD_sgn;
                            ovf_err   <= 1'b0;
                            guard_cnt <= guard_len;
                            hdr_cnt   <= '0;
                            state     <= (!guard_len[GW-1] && guard_len != '0) ? ST_GUARD : ST_HDR;
                        end
                    end
                    ST_GUARD: begin
                        if (guard_cnt == GW'(1)) state <= ST_HDR;
                        else                     guard_cnt <= guard_cnt - GW'(1);
                    end
                    ST_HDR: begin
                        hdr_sr  <= hdr_next[30:0];
                        hdr_cnt <= hdr_cnt + 5'd1;
                        if (hdr_cnt == 5'(HDR_SYMS - 1)) begin
                            if (!hdr_chk_ok(hdr_next)) begin
                                hdr_err  <= 1'b1;
                                pkt_done <= 1'b1;
                                state    <= ST_IDLE;
                            end else if (hdr_next[HDR_LEN_LSB +: 16] == '0) begin
                                pkt_done <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                is_bpsk  <= pick_bpsk(MODE_CTRL, hdr_next[HDR_MCS_LSB +: 8]);
                                rem_bits <= RW'({hdr_next[HDR_LEN_LSB +: 16], 3'b000});
                                pack     <= '0;
                                wcnt     <= '0;
                                state    <= ST_PLD;
                            end
                        end
                    end
                    default: begin
                        rem_bits <= rem_next;
                        if (push) begin
                            pack <= '0;
                            wcnt <= '0;
                        end else begin
                            pack <= pack_next[BITS-2:0];
                            wcnt <= wcnt_next;
                        end
                        if (pld_last) begin
                            pkt_done <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    axis_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_word),
        .pop   (data_tready),
        .dout  (pop_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {data_tdata, data_tkeep, data_tlast, data_tuser} = pop_word;
    assign data_tvalid = ~fifo_empty;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_symbol_depacketizer.sv
// Scoreboard bench for symbol_depacketizer: packets are built from byte lists,
// expected words are pushed at stimulus time and popped by an output monitor.
module tb_symbol_depacketizer;
    localparam int BYTES = 2;
    localparam int BITS  = 8 * BYTES;
    localparam int GUARD = 30;
    localparam int FD    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       RX_BD_WINDOW;
    logic [3:0]       MODE_CTRL;
    logic             BD_flag, BD_sgn, sym_valid;
    logic [1:0]       in_QPSK;
    logic [BITS-1:0]  data_tdata;
    logic [BYTES-1:0] data_tkeep;
    logic             data_tvalid, data_tready, data_tlast, data_tuser;
    logic             busy, pkt_done, hdr_err, ovf_err;

    always #5 clk = ~clk;

    symbol_depacketizer #(
        .BYTES(BYTES), .MAX_WINDOW_WIDTH(8), .GUARD_SYMS(GUARD),
        .LEN_WIDTH(16), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .RX_BD_WINDOW(RX_BD_WINDOW), .MODE_CTRL(MODE_CTRL),
        .BD_flag(BD_flag), .BD_sgn(BD_sgn), .sym_valid(sym_valid), .in_QPSK(in_QPSK),
        .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tvalid(data_tvalid),
        .data_tready(data_tready), .data_tlast(data_tlast), .data_tuser(data_tuser),
        .busy(busy), .pkt_done(pkt_done), .hdr_err(hdr_err), .ovf_err(ovf_err)
    );

    typedef struct packed {
        logic [BITS-1:0]  data;
        logic [BYTES-1:0] keep;
        logic             last;
        logic             user;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] payload[$];
    int         vectors = 0;
    int         errors  = 0;
    int         done_cnt = 0;
    int         herr_cnt = 0;
    int         rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_done) done_cnt++;
            if (hdr_err)  herr_cnt++;
        end
    end

    word_t cur, held, e_mon;
    logic  stall = 1'b0;
    always @(negedge clk) begin
        cur = {data_tdata, data_tkeep, data_tlast, data_tuser};
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) check("hold_stable", {data_tvalid, cur}, {1'b1, held});
            if (data_tvalid && data_tready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", data_tvalid, 1'b0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("tdata", data_tdata, e_mon.data);
                    check("tkeep", data_tkeep, e_mon.keep);
                    check("tlast", data_tlast, e_mon.last);
                    check("tuser", data_tuser, e_mon.user);
                end
            end
            stall = data_tvalid && !data_tready;
            held  = cur;
        end
    end

    task automatic step(input logic v, input logic bd, input logic sg, input logic [1:0] s);
        sym_valid = v;
        BD_flag   = bd;
        BD_sgn    = sg;
        in_QPSK   = s;
        case (rdy_mode)
            0:       data_tready = 1'b1;
            2:       data_tready = 1'b0;
            default: data_tready = ($urandom_range(0, 3) != 0);
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
    endtask

    task automatic tx(input logic bd, input logic [1:0] s, input int gap);
        while ($urandom_range(0, 99) < gap) idle(1);
        step(1'b1, bd, 1'($urandom), s);
    endtask

    // Payload bytes come from the global list; keep_words < 0 expects every word.
    task automatic send_pkt(input logic sg, input logic [7:0] win, input logic [3:0] mode,
                            input logic [7:0] mcs, input logic bad, input int gap,
                            input int keep_words, input int abort_at);
        int         len;
        logic [15:0] l16;
        logic [7:0] chk;
        logic [31:0] hdr;
        logic       bpsk;
        int         glen, d0, h0;
        logic       pbits[$];
        word_t      e;
        len  = payload.size();
        l16  = 16'(len);
        chk  = l16[15:8] ^ l16[7:0] ^ mcs;
        if (bad) chk = chk ^ 8'h04;
        hdr  = {l16, mcs, chk};
        bpsk = (mode == 4'b0001) || (mode != 4'b0010 && !mcs[0]);
        d0   = done_cnt;
        h0   = herr_cnt;
        if (!bad && len > 0) begin
            for (int w = 0; w * BYTES < len; w++) begin
                e = '0;
                for (int b = 0; b < BYTES; b++) begin
                    if (w * BYTES + b < len) begin
                        e.data[BITS-1-8*b -: 8] = payload[w*BYTES+b];
                        e.keep[BYTES-1-b]       = 1'b1;
                    end
                end
                e.last = ((w + 1) * BYTES >= len);
                e.user = bpsk;
                if (keep_words < 0 || w < keep_words) exp_q.push_back(e);
            end
        end
        RX_BD_WINDOW = win;
        MODE_CTRL    = mode;
        while ($urandom_range(0, 99) < gap) idle(1);
        step(1'b1, 1'b1, sg, 2'($urandom));
        glen = GUARD - int'(win);
        for (int i = 0; i < glen; i++) tx(($urandom_range(0, 5) == 0), 2'($urandom), gap);
        for (int i = 31; i >= 0; i--) tx(($urandom_range(0, 5) == 0), {hdr[i] ^ sg, 1'($urandom)}, gap);
        if (!bad && len > 0) begin
            for (int b = 0; b < len; b++)
                for (int k = 7; k >= 0; k--) pbits.push_back(payload[b][k]);
            for (int i = 0; i < pbits.size(); i += (bpsk ? 1 : 2)) begin
                if (i == abort_at) begin
                    check("pre_abort_tvalid", data_tvalid, 1'b1);
                    rst_n = 1'b0;
                    return;
                end
                if (bpsk) tx(($urandom_range(0, 5) == 0), {pbits[i] ^ sg, 1'($urandom)}, gap);
                else      tx(($urandom_range(0, 5) == 0), {pbits[i] ^ sg, pbits[i+1] ^ sg}, gap);
            end
        end
        idle(3);
        check("pkt_done_pulses", done_cnt - d0, 1);
        check("hdr_err_pulses", herr_cnt - h0, bad);
        check("busy_after_pkt", busy, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || data_tvalid) && n < 300) begin
            idle(1);
            n++;
        end
        check("drain_queue_left", exp_q.size(), 0);
    endtask

    task automatic rand_payload(input int n);
        payload = {};
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    logic [3:0] modes[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    initial begin
        rst_n = 1'b0; sym_valid = 1'b0; BD_flag = 1'b0; BD_sgn = 1'b0; in_QPSK = 2'b00;
        RX_BD_WINDOW = 8'd30; MODE_CTRL = 4'b0100; data_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", data_tvalid, 1'b0);
        check("rst_tdata", data_tdata, '0);
        check("rst_tkeep", data_tkeep, '0);
        check("rst_tlast", data_tlast, 1'b0);
        check("rst_tuser", data_tuser, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {pkt_done, hdr_err, ovf_err}, 3'b000);
        rst_n = 1'b1;
        idle(2);

        payload = {8'hA5, 8'h3C};
        send_pkt(1'b0, 8'd28, 4'b0100, 8'h00, 1'b0, 0, -1, -1);
        payload = {8'h12, 8'h34, 8'h56};
        send_pkt(1'b0, 8'd30, 4'b0100, 8'h01, 1'b0, 0, -1, -1);
        send_pkt(1'b1, 8'd30, 4'b0100, 8'h01, 1'b0, 20, -1, -1);
        send_pkt(1'b0, 8'd30, 4'b0100, 8'h00, 1'b1, 0, -1, -1);
        payload = {};
        send_pkt(1'b0, 8'd25, 4'b0100, 8'h00, 1'b0, 0, -1, -1);
        rand_payload(3);
        send_pkt(1'b0, 8'd40, 4'b0001, 8'h01, 1'b0, 10, -1, -1);
        rand_payload(4);
        send_pkt(1'b1, 8'd0, 4'b0010, 8'h00, 1'b0, 10, -1, -1);
        rand_payload(5);
        send_pkt(1'b0, 8'd29, 4'b1000, 8'h01, 1'b0, 10, -1, -1);
        drain();

        rdy_mode = 1;
        for (int p = 0; p < 20; p++) begin
            rand_payload($urandom_range(1, 7));
            send_pkt(1'($urandom), 8'($urandom_range(22, 34)), modes[$urandom_range(0, 4)],
                     8'($urandom), ($urandom_range(0, 5) == 0), 30, -1, -1);
            check("ovf_clear", ovf_err, 1'b0);
        end
        drain();

        rdy_mode = 2;
        rand_payload(12);
        send_pkt(1'b0, 8'd30, 4'b0100, 8'h00, 1'b0, 0, FD, -1);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_tvalid", data_tvalid, 1'b1);
        drain();
        check("ovf_sticky", ovf_err, 1'b1);
        rand_payload(2);
        send_pkt(1'b0, 8'd30, 4'b0010, 8'h00, 1'b0, 0, -1, -1);
        check("ovf_cleared_by_bd", ovf_err, 1'b0);
        drain();

        rdy_mode = 2;
        rand_payload(4);
        send_pkt(1'b0, 8'd30, 4'b0100, 8'h00, 1'b0, 0, 0, 20);
        @(negedge clk);
        check("abort_tvalid", data_tvalid, 1'b0);
        check("abort_outputs", {data_tdata, data_tkeep, data_tlast, data_tuser}, '0);
        check("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        idle(10);
        check("abort_no_words", data_tvalid, 1'b0);
        rand_payload(3);
        send_pkt(1'b1, 8'd27, 4'b0100, 8'h01, 1'b0, 10, -1, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
